systolic_conv_drain: RTL and testbench
======================================

SYSTOLIC_CONV_DRAIN -- requirements
Module: systolic_conv_drain

Interface
REQ-001 Parameter DATA_W, default 8, width of each result element and of m_data.
REQ-002 Parameter SEQ_W, default 8, width of the frame sequence counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 res_valid  input  1  one-cycle pulse; c11..c22 hold a complete 2x2 convolution result.
REQ-006 c11, c12, c21, c22  input  DATA_W each  result elements from the 3x3 systolic array.
REQ-007 m_valid  output  1  stream byte valid.
REQ-008 m_ready  input  1  downstream accepts byte when high with m_valid.
REQ-009 m_data  output  DATA_W  stream byte.
REQ-010 m_last  output  1  high on the final byte of a frame.
REQ-011 busy  output  1  high while any frame slot is occupied.
REQ-012 overflow  output  1  sticky; a frame was dropped.
REQ-013 frame_cnt  output  SEQ_W  count of frames fully drained, wraps at 2^SEQ_W.

Function
REQ-014 The block SHALL hold two frame slots: active (being streamed) and pending.
REQ-015 On res_valid, the block SHALL capture c11..c22 into active if empty, else into pending if empty, else drop the frame and set overflow.
REQ-016 The FSM SHALL have states IDLE, HDR (header build only), SEND; IDLE->HDR/SEND on capture into empty active; SEND->IDLE after last handshake with no pending frame.
REQ-017 Byte order in SEND SHALL be c11, c12, c21, c22; m_last high only with c22.
REQ-018 A byte transfers on a clock edge where m_valid and m_ready are both high; the element index advances only on transfer.
REQ-019 While m_valid is high and m_ready low, m_data and m_last SHALL hold stable.
REQ-020 Latency: res_valid sampled at edge k in IDLE SHALL yield m_valid high after edge k.
REQ-021 On the last-byte transfer with pending full, pending SHALL move to active and m_valid SHALL stay high with the next frame's first byte; no bubble cycle.
REQ-022 res_valid coinciding with a last-byte transfer while pending full SHALL load the new frame into pending, not drop it; overflow unchanged.
REQ-023 res_valid coinciding with a last-byte transfer while pending empty and active-only SHALL load active directly, with no bubble.
REQ-024 frame_cnt SHALL increment on each last-byte transfer, wrapping 2^SEQ_W-1 -> 0.
REQ-025 A per-frame sequence tag SHALL be assigned at capture from a SEQ_W counter of accepted frames; dropped frames consume no tag.

Reset
REQ-026 On rst: m_valid=0, m_data=0, m_last=0, busy=0, overflow=0, frame_cnt=0, sequence counter=0, both slots empty, FSM IDLE.
REQ-027 rst asserted mid-frame SHALL discard active and pending data immediately; no partial frame resumes after release.
REQ-028 overflow SHALL clear only by rst.

Configuration
REQ-029 With DRAIN_HDR_EN defined, each frame SHALL begin with one header byte equal to its sequence tag (zero-extended to DATA_W) in state HDR, then four data bytes; m_last still on c22 only.
REQ-030 Without DRAIN_HDR_EN, state HDR SHALL not exist and frames are exactly four bytes.

Structure
REQ-031 Package systolic_pkg SHALL hold DATA_W/SEQ_W defaults, the FSM state enum, and element-index constants (IDX_C11..IDX_C22).
REQ-032 Sub-module drain_frame_buf SHALL implement the two-slot frame storage with push/pop/full/empty; FSM and stream logic stay in the top.

Verification
REQ-033 Image 1..16 row-major, all-ones filter, res_valid pulse, m_ready=1 -> bytes 54, 63, 90, 99; m_last on 99; frame_cnt=1.
REQ-034 Same frame, m_ready low for 3 cycles after first byte -> 54 held stable 3 cycles, then 63, 90, 99 unchanged.
REQ-035 Three res_valid pulses 1 cycle apart, m_ready=0 -> first two frames kept, overflow=1; releasing m_ready drains 8 bytes, frame_cnt=2.
REQ-036 Second res_valid on the cycle of first frame's 99 transfer -> next byte 54 on the following cycle, no m_valid gap, overflow=0.
REQ-037 rst pulse (20 ns) after byte 63 -> all outputs zero, next res_valid restarts at 54, frame_cnt=1 after drain.
REQ-038 With DRAIN_HDR_EN, two frames -> stream 0, 54, 63, 90, 99, 1, 54, 63, 90, 99; m_last on both 99s.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared constants and FSM encoding for the systolic result drain.
// Build with DRAIN_HDR_EN defined to prepend a sequence-tag header byte.
package systolic_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int SEQ_W_DEF  = 8;
   localparam int NUM_EL     = 4;

   localparam logic [1:0] IDX_C11 = 2'd0;
   localparam logic [1:0] IDX_C12 = 2'd1;
   localparam logic [1:0] IDX_C21 = 2'd2;
   localparam logic [1:0] IDX_C22 = 2'd3;

`ifdef DRAIN_HDR_EN
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HDR,
      ST_SEND
   } state_e;
   localparam state_e ST_FIRST = ST_HDR;
`else
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEND
   } state_e;
   localparam state_e ST_FIRST = ST_SEND;
`endif

endpackage

// File: rtl/drain_frame_buf.sv
// Two-slot frame store: active slot feeds the stream, pending queues one frame.
// A pop and a push on the same edge shift pending forward, then fill the first free slot.
module drain_frame_buf
   import systolic_pkg::*;
#(
   parameter int W = 4 * DATA_W_DEF + SEQ_W_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic [W-1:0] push_data_i,
   input  logic         pop_i,
   output logic [W-1:0] act_data_o,
   output logic         full_o,
   output logic         empty_o
);

   logic         act_vld_q, act_vld_d;
   logic         pnd_vld_q, pnd_vld_d;
   logic [W-1:0] act_q, act_d;
   logic [W-1:0] pnd_q, pnd_d;

   always_comb begin
      act_vld_d = act_vld_q;
      pnd_vld_d = pnd_vld_q;
      act_d     = act_q;
      pnd_d     = pnd_q;
      if (pop_i) begin
         act_vld_d = pnd_vld_q;
         act_d     = pnd_q;
         pnd_vld_d = 1'b0;
      end
      if (push_i && !(act_vld_d && pnd_vld_d)) begin
         if (!act_vld_d) begin
            act_vld_d = 1'b1;
            act_d     = push_data_i;
         end else begin
            pnd_vld_d = 1'b1;
            pnd_d     = push_data_i;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         act_vld_q <= 1'b0;
         pnd_vld_q <= 1'b0;
         act_q     <= '0;
         pnd_q     <= '0;
      end else begin
         act_vld_q <= act_vld_d;
         pnd_vld_q <= pnd_vld_d;
         act_q     <= act_d;
         pnd_q     <= pnd_d;
      end
   end

   assign act_data_o = act_q;
   assign full_o     = act_vld_q && pnd_vld_q;
   assign empty_o    = !act_vld_q;

endmodule

// File: rtl/systolic_conv_drain.sv
// Streams 2x2 convolution results out as c11,c12,c21,c22 bytes over valid/ready.
// DRAIN_HDR_EN adds a leading header byte carrying the frame sequence tag.
module systolic_conv_drain
   import systolic_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int SEQ_W  = SEQ_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              res_valid,
   input  logic [DATA_W-1:0] c11,
   input  logic [DATA_W-1:0] c12,
   input  logic [DATA_W-1:0] c21,
   input  logic [DATA_W-1:0] c22,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   output logic              busy,
   output logic              overflow,
   output logic [SEQ_W-1:0]  frame_cnt
);

   localparam int FW = NUM_EL * DATA_W + SEQ_W;

   state_e            state_q, state_d;
   logic [1:0]        idx_q, idx_d;
   logic [SEQ_W-1:0]  seq_q, seq_d;
   logic [SEQ_W-1:0]  fcnt_q, fcnt_d;
   logic              ovf_q, ovf_d;

   logic [FW-1:0]     act_data;
   logic              buf_full;
   logic              buf_empty;
   logic              xfer;
   logic              pop;
   logic              drop;
   logic              push;
   logic [DATA_W-1:0] el;
   logic [SEQ_W-1:0]  act_tag;

   assign m_valid = (state_q != ST_IDLE);
   assign m_last  = (state_q == ST_SEND) && (idx_q == IDX_C22);
   assign xfer    = m_valid && m_ready;
   assign pop     = xfer && m_last;
   assign drop    = res_valid && buf_full && !pop;
   assign push    = res_valid && !drop;
   assign act_tag = act_data[NUM_EL*DATA_W +: SEQ_W];

   drain_frame_buf #(
      .W (FW)
   ) u_buf (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push),
      .push_data_i ({seq_q, c22, c21, c12, c11}),
      .pop_i       (pop),
      .act_data_o  (act_data),
      .full_o      (buf_full),
      .empty_o     (buf_empty)
   );

   always_comb begin
      el = act_data[0 +: DATA_W];
      unique case (idx_q)
         IDX_C11: el = act_data[0 +: DATA_W];
         IDX_C12: el = act_data[DATA_W +: DATA_W];
         IDX_C21: el = act_data[2*DATA_W +: DATA_W];
         IDX_C22: el = act_data[3*DATA_W +: DATA_W];
      endcase
   end

   always_comb begin
      m_data = '0;
      if (state_q == ST_SEND) begin
         m_data = el;
      end
`ifdef DRAIN_HDR_EN
      if (state_q == ST_HDR) begin
         m_data = DATA_W'(act_tag);
      end
`endif
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      seq_d   = push ? seq_q + SEQ_W'(1) : seq_q;
      fcnt_d  = pop ? fcnt_q + SEQ_W'(1) : fcnt_q;
      ovf_d   = ovf_q || drop;
      unique case (state_q)
         ST_IDLE: begin
            if (res_valid) begin
               state_d = ST_FIRST;
               idx_d   = IDX_C11;
            end
         end
`ifdef DRAIN_HDR_EN
         ST_HDR: begin
            if (xfer) begin
               state_d = ST_SEND;
               idx_d   = IDX_C11;
            end
         end
`endif
         ST_SEND: begin
            if (xfer) begin
               if (idx_q == IDX_C22) begin
                  idx_d = IDX_C11;
                  // pending, or a frame arriving now, continues without a bubble
                  state_d = (buf_full || res_valid) ? ST_FIRST : ST_IDLE;
               end else begin
                  idx_d = idx_q + 2'd1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            idx_d   = IDX_C11;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= IDX_C11;
         seq_q   <= '0;
         fcnt_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         seq_q   <= seq_d;
         fcnt_q  <= fcnt_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy      = !buf_empty;
   assign overflow  = ovf_q;
   assign frame_cnt = fcnt_q;

endmodule

// File: tb/tb_systolic_conv_drain.sv
// Scoreboard bench: a frame-level model queues expected bytes, a monitor checks them.
// Define DRAIN_HDR_EN to exercise the header-byte build.
module tb_systolic_conv_drain;
   import systolic_pkg::*;

   localparam int DW = 8;
   localparam int SW = 8;
`ifdef DRAIN_HDR_EN
   localparam int FLEN = 5;
`else
   localparam int FLEN = 4;
`endif

   typedef struct packed {
      logic [DW-1:0] d;
      logic          l;
   } exp_t;
   typedef logic [3:0][DW-1:0] frm_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          res_valid = 1'b0;
   logic          m_ready = 1'b0;
   logic [DW-1:0] c11 = '0, c12 = '0, c21 = '0, c22 = '0;
   logic          m_valid, m_last, busy, overflow;
   logic [DW-1:0] m_data;
   logic [SW-1:0] frame_cnt;

   exp_t          sb[$];
   int            checks = 0;
   int            errors = 0;
   int            frames = 0;
   int            left = 0;
   logic [SW-1:0] tag_m = '0;
   logic [SW-1:0] fcnt_m = '0;
   bit            ovf_m = 1'b0;
   frm_t          img;
   frm_t          zf;

   always #5 clk = ~clk;

   systolic_conv_drain #(.DATA_W(DW), .SEQ_W(SW)) dut (
      .clk       (clk),
      .rst       (rst),
      .res_valid (res_valid),
      .c11       (c11),
      .c12       (c12),
      .c21       (c21),
      .c22       (c22),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .m_last    (m_last),
      .busy      (busy),
      .overflow  (overflow),
      .frame_cnt (frame_cnt)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_step();
      exp_t b;
      if (rst) return;
      if (m_ready && frames > 0) begin
         left--;
         if (left == 0) begin
            frames--;
            fcnt_m++;
            if (frames > 0) left = FLEN;
         end
      end
      if (res_valid) begin
         if (frames < 2) begin
`ifdef DRAIN_HDR_EN
            b.d = DW'(tag_m); b.l = 1'b0; sb.push_back(b);
`endif
            b.d = c11; b.l = 1'b0; sb.push_back(b);
            b.d = c12; b.l = 1'b0; sb.push_back(b);
            b.d = c21; b.l = 1'b0; sb.push_back(b);
            b.d = c22; b.l = 1'b1; sb.push_back(b);
            tag_m++;
            if (frames == 0) left = FLEN;
            frames++;
         end else begin
            ovf_m = 1'b1;
         end
      end
   endtask

   task automatic cyc(input bit v, input bit r, input frm_t f);
      @(posedge clk);
      model_step();
      #2;
      res_valid = v;
      m_ready   = r;
      c11 = f[0]; c12 = f[1]; c21 = f[2]; c22 = f[3];
   endtask

   task automatic do_reset();
      @(posedge clk);
      model_step();
      #2;
      rst = 1'b1;
      res_valid = 1'b0;
      m_ready = 1'b0;
      sb.delete();
      frames = 0; left = 0; tag_m = '0; fcnt_m = '0; ovf_m = 1'b0;
      #20;
      rst = 1'b0;
   endtask

   function automatic frm_t rnd_frm();
      frm_t f;
      for (int i = 0; i < 4; i++) f[i] = DW'($urandom());
      return f;
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_m_valid", 32'(m_valid), 32'(0));
         chk("rst_m_data", 32'(m_data), 32'(0));
         chk("rst_m_last", 32'(m_last), 32'(0));
         chk("rst_busy", 32'(busy), 32'(0));
         chk("rst_overflow", 32'(overflow), 32'(0));
         chk("rst_frame_cnt", 32'(frame_cnt), 32'(0));
      end else begin
         chk("m_valid", 32'(m_valid), 32'(frames > 0));
         chk("busy", 32'(busy), 32'(frames > 0));
         chk("overflow", 32'(overflow), 32'(ovf_m));
         chk("frame_cnt", 32'(frame_cnt), 32'(fcnt_m));
         if (m_valid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_underrun: got byte %0d expected none", m_data);
            end else begin
               chk("m_data", 32'(m_data), 32'(sb[0].d));
               chk("m_last", 32'(m_last), 32'(sb[0].l));
               if (m_ready) void'(sb.pop_front());
            end
         end
      end
   end

   initial begin
      int s;
      zf = '0;
      for (int i = 0; i < 2; i++) begin
         for (int j = 0; j < 2; j++) begin
            s = 0;
            for (int r = 0; r < 3; r++)
               for (int c = 0; c < 3; c++)
                  s += (i + r) * 4 + (j + c) + 1;
            img[i*2+j] = DW'(s);
         end
      end
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;

      cyc(1, 1, img);
      repeat (6) cyc(0, 1, zf);

      cyc(1, 0, img);
      repeat (3) cyc(0, 0, zf);
      repeat (6) cyc(0, 1, zf);

      cyc(1, 1, img);
      repeat (FLEN - 1) cyc(0, 1, zf);
      cyc(1, 1, img);
      repeat (FLEN + 2) cyc(0, 1, zf);

      cyc(1, 0, img);
      cyc(0, 0, zf);
      cyc(1, 0, rnd_frm());
      cyc(0, 0, zf);
      cyc(1, 0, rnd_frm());
      repeat (3) cyc(0, 0, zf);
      repeat (2 * FLEN + 3) cyc(0, 1, zf);

      cyc(1, 1, img);
      cyc(0, 1, zf);
      cyc(0, 1, zf);
      do_reset();
      cyc(1, 1, img);
      repeat (FLEN + 2) cyc(0, 1, zf);

      for (int n = 0; n < 270; n++) begin
         cyc(1, 1, rnd_frm());
         repeat (FLEN - 1) cyc(0, 1, zf);
      end

      for (int n = 0; n < 2000; n++)
         cyc($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
             rnd_frm());

      for (int n = 0; n < 40 && (frames > 0 || sb.size() > 0); n++)
         cyc(0, 1, zf);
      @(negedge clk);
      #1;
      chk("sb_drained", 32'(sb.size()), 32'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
